// File: rtl/peak_abs_mc.sv
// ---------------------------------------------------------------------------
// peak_abs_mc
//
// Multi-channel absolute-peak finder with a runtime frame length. Each
// accepted input beat carries NUM_CH signed samples. For every channel the
// block tracks the largest |x| in the frame and the frame index where it first
// occurred. At frame end it streams one result per channel, channel 0 first.
//
// Optional feature (compile-time macro PEAK_ABS_MC_THRESH_EN):
//   When defined, adds a threshold input and a per-channel count of the frame
//   samples whose |x| exceeds it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   frame-start request, honoured only in IDLE
//   frame_len  in   samples per frame, latched on accepted start (clamped to
//                   MAX_SAMPLES; 0 ignores the start)
//   thresh     in   [ifdef] unsigned |x| threshold, latched on accepted start
//   in_valid   in   input beat valid
//   in_ready   out  high only while accumulating
//   sample_in  in   channel c in bits [c*WIDTH +: WIDTH], two's complement
//   out_valid  out  result valid (high throughout DRAIN)
//   out_ready  in   result accepted
//   out_ch     out  channel of the current result
//   peak_out   out  unsigned |x| peak of out_ch
//   peak_idx   out  frame index of that peak
//   over_cnt   out  [ifdef] samples on out_ch with |x| > thresh
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
module peak_abs_mc #(
  parameter  int WIDTH       = 16,
  parameter  int NUM_CH      = 4,
  parameter  int MAX_SAMPLES = 1024,
  localparam int IDX_W       = $clog2(MAX_SAMPLES),
  localparam int LEN_W       = $clog2(MAX_SAMPLES + 1),
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          frame_len,
`ifdef PEAK_ABS_MC_THRESH_EN
  input  logic [WIDTH-1:0]          thresh,
  output logic [LEN_W-1:0]          over_cnt,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CH*WIDTH-1:0]   sample_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_ch,
  output logic [WIDTH-1:0]          peak_out,
  output logic [IDX_W-1:0]          peak_idx,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamp;
  logic [IDX_W-1:0] cnt_q;
  logic [CH_W-1:0]  ch_ptr;
  logic [WIDTH-1:0] peak_q [NUM_CH];
  logic [IDX_W-1:0] idx_q  [NUM_CH];
  logic [WIDTH-1:0] mag    [NUM_CH];
`ifdef PEAK_ABS_MC_THRESH_EN
  logic [WIDTH-1:0] thresh_q;
  logic [LEN_W-1:0] over_q [NUM_CH];
`endif

  logic start_ok, beat, last_beat, take, last_ch;

  // |x| computed in WIDTH+1 bits and truncated to WIDTH is identical to the
  // WIDTH-bit two's complement negate, so the most-negative input maps to
  // 2^(WIDTH-1) without needing the extra bit.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign len_clamp = (frame_len > LEN_W'(MAX_SAMPLES)) ? LEN_W'(MAX_SAMPLES) : frame_len;
  assign start_ok  = (state == IDLE) && start && (frame_len != '0);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign beat      = in_valid && in_ready;
  assign last_beat = (LEN_W'(cnt_q) + LEN_W'(1)) == len_q;
  assign take      = out_valid && out_ready;
  assign last_ch   = (ch_ptr == CH_W'(NUM_CH - 1));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mag[c] = abs_w(sample_in[c*WIDTH +: WIDTH]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok)          state_nxt = ACCUM;
      ACCUM:   if (beat && last_beat) state_nxt = DRAIN;
      DRAIN:   if (take && last_ch)   state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // NOTE: the tracker arrays are small register files and are reset
  // explicitly, so an aborted frame can never leak partial peaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      ch_ptr <= '0;
      done   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        peak_q[c] <= '0;
        idx_q[c]  <= '0;
      end
`ifdef PEAK_ABS_MC_THRESH_EN
      thresh_q <= '0;
      for (int c = 0; c < NUM_CH; c++) over_q[c] <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            len_q  <= len_clamp;
            cnt_q  <= '0;
            ch_ptr <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              peak_q[c] <= '0;
              idx_q[c]  <= '0;
            end
`ifdef PEAK_ABS_MC_THRESH_EN
            thresh_q <= thresh;
            for (int c = 0; c < NUM_CH; c++) over_q[c] <= '0;
`endif
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_q + IDX_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
              // Strict compare: on ties the earliest index is kept.
              if (mag[c] > peak_q[c]) begin
                peak_q[c] <= mag[c];
                idx_q[c]  <= cnt_q;
              end
`ifdef PEAK_ABS_MC_THRESH_EN
              if ((mag[c] > thresh_q) && (over_q[c] < len_q))
                over_q[c] <= over_q[c] + LEN_W'(1);
`endif
            end
          end
        end
        DRAIN: begin
          if (take) begin
            ch_ptr <= last_ch ? '0 : ch_ptr + CH_W'(1);
            done   <= last_ch;
          end
        end
        default: ;
      endcase
    end
  end

  // Result fields are forced to zero outside DRAIN; inside DRAIN they only
  // depend on ch_ptr, which holds while out_ready is low.
  assign out_ch   = ch_ptr;
  assign peak_out = out_valid ? peak_q[ch_ptr] : '0;
  assign peak_idx = out_valid ? idx_q[ch_ptr]  : '0;
`ifdef PEAK_ABS_MC_THRESH_EN
  assign over_cnt = out_valid ? over_q[ch_ptr] : '0;
`endif

endmodule

// File: doc/peak_abs_mc.md
# peak_abs_mc

Multi-channel, runtime-framed successor to the single-channel absolute-peak finder. It accepts one packed beat of `NUM_CH` signed samples per accepted transfer over a frame of runtime length `frame_len`. It tracks each channel's largest |x| and that sample's index within the frame. At frame end it streams one result per channel over a valid/ready output. It sits between the ADC sample front-end and the host-readout/feature stage.

## Interface
- `WIDTH`, 16, signed sample width per channel
- `NUM_CH`, 4, channels packed per input beat (≥1)
- `MAX_SAMPLES`, 1024, largest supported frame length (≥2)
- Derived: `IDX_W = $clog2(MAX_SAMPLES)`, `LEN_W = $clog2(MAX_SAMPLES+1)`, `CH_W = max(1,$clog2(NUM_CH))`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  frame-start request, honoured only in IDLE
- `frame_len`  in  LEN_W  samples per frame, latched on accepted `start`
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  high only in ACCUM
- `sample_in`  in  NUM_CH*WIDTH  channel c in bits [c*WIDTH +: WIDTH], two's complement
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result accepted
- `out_ch`  out  CH_W  channel of current result
- `peak_out`  out  WIDTH  unsigned |x| peak
- `peak_idx`  out  IDX_W  frame index of peak
- `busy`  out  1  high when not IDLE
- `done`  out  1  one-cycle pulse after last result accepted

## Operation
- FSM has states IDLE, ACCUM and DRAIN. Reset enters IDLE.
- **IDLE:**
  - `start`=1 with `frame_len`≠0 latches len = min(`frame_len`, `MAX_SAMPLES`), zeroes all trackers and the sample counter, and moves to ACCUM.
  - `start` with `frame_len`=0 is ignored.
- **ACCUM:**
  - Each beat with `in_valid`&&`in_ready` computes abs per channel.
  - Abs is taken in WIDTH+1 bits, then truncated to WIDTH unsigned. The most-negative input yields 2^(WIDTH-1).
  - If abs > tracked peak (strict), the tracker takes peak = abs and idx = counter. On ties the first occurrence wins.
  - Trackers reset to peak 0, idx 0. An all-zero channel therefore reports 0/0.
  - The counter increments per beat. The beat with counter = len-1 moves the FSM to DRAIN with ch_ptr = 0.
- **DRAIN:**
  - `out_valid`=1; `out_ch`=ch_ptr; `peak_out`/`peak_idx` come from tracker[ch_ptr].
  - On `out_valid`&&`out_ready`, ch_ptr increments.
  - Acceptance of channel NUM_CH-1 moves to IDLE and pulses `done` in the following cycle.
- `start` outside IDLE is ignored. `in_valid` outside ACCUM is not accepted (`in_ready`=0) and the bench must hold the data.
- Output data is stable while `out_valid`&&!`out_ready`.
- **Reset mid-operation:** the next cycle is IDLE, and partial trackers are discarded. No `out_valid` or `done` results from the aborted frame.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_ch`=0, `peak_out`=0, `peak_idx`=0, `busy`=0, `done`=0.
- `start` accepted at edge E: `in_ready`=1 and `busy`=1 from cycle E+1.
- Last beat accepted at edge L: `in_ready`=0 and `out_valid`=1 (channel 0, final values including beat L) from cycle L+1. Latency is one cycle.
- With `out_ready` held high, one result per cycle: NUM_CH cycles of `out_valid`.
- Last result accepted at edge D: `done`=1 and `busy`=0 in cycle D+1. A new `start` may be accepted at edge D+1.
- Minimum frame period is 1 + len + NUM_CH cycles.

## Configuration
- `PEAK_ABS_MC_THRESH_EN` defined:
  - Adds input `thresh` [WIDTH-1:0] (unsigned), latched on accepted `start`.
  - Adds output `over_cnt` [LEN_W-1:0], which is the count of frame samples on `out_ch` with abs > `thresh`. It saturates at len, resets to 0, and is stable under backpressure like the peak fields.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- **Basic frame:** NUM_CH=4, len=16.
  - ch0 = {12,-45,78,-300,150,-200,50,0,-1024,77,25,-999,500,-250,1023,-700}; ch1 = 0s; ch2 = idx·3; ch3 = -idx.
  - Expected results in order: (0,1024,8), (1,0,0), (2,45,15), (3,15,15).
  - `done` pulses once.
- **Tie and extreme:** ch0 = {5,-5,5,-32768,32767}.
  - Expected: peak 32768 at idx 3.
  - A separate frame {-7,7} reports 7 at idx 0.
- **Backpressure:** `out_ready` low for 3 cycles in DRAIN.
  - `out_ch`=0 and its data are held unchanged.
  - Toggling `out_ready` every other cycle yields all 4 channels in order, with no skip and no repeat.
- **Input stall:** `in_valid` gaps of 0–3 cycles mid-frame give results identical to the gap-free frame. `in_valid` in IDLE/DRAIN is not accepted and the counter is unchanged.
- **Boundaries and reset:**
  - `start` with `frame_len`=0 leaves `busy`=0.
  - len=1: `out_valid` one cycle after the single beat.
  - `frame_len`=MAX_SAMPLES+1 takes exactly MAX_SAMPLES beats.
  - `rst` after 5 of 16 beats gives all outputs at reset values next cycle. A fresh frame then reports correct results.
- **With `PEAK_ABS_MC_THRESH_EN`:** `thresh`=100 on the basic-frame ch0 → `over_cnt`=9. ch1 → 0.
